// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and helpers for the store queue: the queue
//                pointer type (index plus wrap bit), the store queue entry
//                record and the age comparison used by the forwarding search.
//                The lsq_store_fu width parameters default to the constants
//                below and must stay equal to them, because the entry record
//                is sized from these constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int MEM_SQ_DEPTH = 8;
  localparam int MEM_ADDR_W   = 64;
  localparam int MEM_DATA_W   = 64;
  localparam int MEM_BMASK_W  = 4;
  localparam int MEM_PTR_W    = $clog2(MEM_SQ_DEPTH) + 1;

  typedef logic [MEM_PTR_W-1:0] sq_ptr_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0]  addr;
    logic [MEM_DATA_W-1:0]  data;
    logic                   addr_vld;
    logic [MEM_BMASK_W-1:0] bmask;
  } sq_entry_t;

  // True when pointer a is strictly older than pointer b, with age measured
  // as the modular distance from head. The wrap bit makes the distance exact
  // for a queue holding up to SQ_DEPTH entries.
  function automatic logic ptr_older(sq_ptr_t a, sq_ptr_t b, sq_ptr_t head);
    sq_ptr_t w_age_a;
    sq_ptr_t w_age_b;
    w_age_a = a - head;
    w_age_b = b - head;
    return (w_age_a < w_age_b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sq_fwd_search.sv
`default_nettype none
// ============================================================================
//  Module      : sq_fwd_search
//  Description : Combinational store-to-load forwarding search for one lane.
//                Scans the queue from the load's tail snapshot down towards
//                head, youngest store first, and stops at the first entry
//                that decides the outcome.
//  Ports       : i_q        - registered store queue contents
//                i_head     - queue head pointer
//                i_ld_tail  - tail snapshot taken when the load dispatched
//                i_ld_addr  - load effective address
//                o_hit      - an older resolved store matches the address
//                o_replay   - an unresolved store is younger than any match
//                o_data     - data of the matching store
//  Revision    : 1.0 - initial release
// ============================================================================
module sq_fwd_search
  import mem_pkg::*;
#(
  parameter int SQ_DEPTH = MEM_SQ_DEPTH
) (
  input  sq_entry_t             i_q [SQ_DEPTH],
  input  sq_ptr_t               i_head,
  input  sq_ptr_t               i_ld_tail,
  input  logic [MEM_ADDR_W-1:0] i_ld_addr,
  output logic                  o_hit,
  output logic                  o_replay,
  output logic [MEM_DATA_W-1:0] o_data
);

  localparam int IDX_W = $clog2(SQ_DEPTH);

  sq_ptr_t w_ptr;
  logic    w_done;
  logic    w_unused_bmask;

  // Step k visits ld_tail-1-k. Entries outside [head, ld_tail) fail the age
  // test, so the loop is bounded by the queue size rather than occupancy.
  // An unresolved store reached first means its address may alias the load.
  always_comb begin
    o_hit    = 1'b0;
    o_replay = 1'b0;
    o_data   = '0;
    w_done   = 1'b0;
    w_ptr    = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      w_ptr = i_ld_tail - sq_ptr_t'(k + 1);
      if (!w_done && ptr_older(w_ptr, i_ld_tail, i_head)) begin
        if (!i_q[w_ptr[IDX_W-1:0]].addr_vld) begin
          o_replay = 1'b1;
          w_done   = 1'b1;
        end else if (i_q[w_ptr[IDX_W-1:0]].addr == i_ld_addr) begin
          o_hit    = 1'b1;
          o_data   = i_q[w_ptr[IDX_W-1:0]].data;
          w_done   = 1'b1;
        end
      end
    end
  end

  // Branch masks play no part in forwarding.
  always_comb begin
    w_unused_bmask = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      w_unused_bmask = w_unused_bmask ^ (^i_q[i].bmask);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsq_store_fu.sv
`default_nettype none
// ============================================================================
//  Module      : lsq_store_fu
//  Description : Memory functional unit owning a circular store queue.
//                Allocates stores at dispatch, latches address/data at
//                execute, forwards store data to loads (or requests replay),
//                tracks retirement, drains committed stores to the dcache
//                controller and restores the tail on branch mispredict.
//  Ports       : clk, reset        - clock, async active-high reset
//                disp_*/sq_alloc_* - per-lane store allocation
//                sq_tail/sq_n_free - tail snapshot and saturated free count
//                fu_*              - per-lane store/load execute inputs
//                ld_*              - per-lane forwarding results
//                rob_n_retire      - stores committed this cycle
//                br_*              - mispredict recovery and mask resolution
//                mem_req_*         - valid/ready drain port
//                sq_empty          - queue occupancy is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module lsq_store_fu
  import mem_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int SQ_DEPTH = MEM_SQ_DEPTH,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int TAG_W    = 6,
  parameter int BMASK_W  = MEM_BMASK_W,
  parameter int PTR_W    = $clog2(SQ_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_LANES-1:0]            disp_alloc,
  input  logic [N_LANES*BMASK_W-1:0]    disp_bmask,
  output logic [N_LANES*PTR_W-1:0]      sq_alloc_idx,
  output logic [PTR_W-1:0]              sq_tail,
  output logic [$clog2(N_LANES+1)-1:0]  sq_n_free,
  input  logic [N_LANES-1:0]            fu_st_en,
  input  logic [N_LANES*PTR_W-1:0]      fu_st_idx,
  input  logic [N_LANES-1:0]            fu_ld_en,
  input  logic [N_LANES*PTR_W-1:0]      fu_ld_tail,
  input  logic [N_LANES*ADDR_W-1:0]     fu_addr,
  input  logic [N_LANES*DATA_W-1:0]     fu_data,
  output logic [N_LANES-1:0]            ld_fwd_hit,
  output logic [N_LANES*DATA_W-1:0]     ld_fwd_data,
  output logic [N_LANES-1:0]            ld_replay,
  input  logic [$clog2(N_LANES+1)-1:0]  rob_n_retire,
  input  logic                          br_mispredict,
  input  logic [PTR_W-1:0]              br_recov_tail,
  input  logic [BMASK_W-1:0]            br_resolve_ok,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_data,
  output logic                          sq_empty
);

  localparam int IDX_W = PTR_W - 1;
  localparam int CNT_W = $clog2(N_LANES + 1);
  localparam int c_unused_tag_w = TAG_W;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_ret;
  sq_entry_t        r_q [SQ_DEPTH];

  logic [PTR_W-1:0] w_occ;
  logic [PTR_W-1:0] w_free;
  logic [PTR_W-1:0] w_alloc_cnt;
  logic [PTR_W-1:0] w_alloc_ptr [N_LANES];
  logic             w_pop;

  assign w_occ     = r_tail - r_head;
  assign w_free    = PTR_W'(SQ_DEPTH) - w_occ;
  assign sq_n_free = (w_free >= PTR_W'(N_LANES)) ? CNT_W'(N_LANES) : CNT_W'(w_free);
  assign sq_tail   = r_tail;
  assign sq_empty  = (r_head == r_tail);

  // Requesting lanes take consecutive pointers in lane order; idle lanes
  // report the pointer the next requesting lane would receive.
  always_comb begin
    w_alloc_cnt  = '0;
    sq_alloc_idx = '0;
    for (int l = 0; l < N_LANES; l++) begin
      w_alloc_ptr[l] = r_tail + w_alloc_cnt;
      sq_alloc_idx[l*PTR_W +: PTR_W] = w_alloc_ptr[l];
      if (disp_alloc[l]) begin
        w_alloc_cnt = w_alloc_cnt + PTR_W'(1);
      end
    end
  end

  // Only committed entries (head up to the retire pointer) are drained.
  assign mem_req_valid = (r_head != r_ret);
  assign mem_req_addr  = r_q[r_head[IDX_W-1:0]].addr;
  assign mem_req_data  = r_q[r_head[IDX_W-1:0]].data;
  assign w_pop         = mem_req_valid & mem_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_ret  <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_ret <= r_ret + PTR_W'(rob_n_retire);
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_q[i].bmask <= r_q[i].bmask & ~br_resolve_ok;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
        r_q[r_head[IDX_W-1:0]].addr_vld <= 1'b0;
      end
      // The recovery snapshot never precedes the retire pointer, so rewinding
      // the tail only discards speculative entries.
      if (br_mispredict) begin
        r_tail <= br_recov_tail;
      end else begin
        r_tail <= r_tail + w_alloc_cnt;
        for (int l = 0; l < N_LANES; l++) begin
          if (disp_alloc[l]) begin
            r_q[w_alloc_ptr[l][IDX_W-1:0]].addr_vld <= 1'b0;
            r_q[w_alloc_ptr[l][IDX_W-1:0]].bmask <=
              disp_bmask[l*BMASK_W +: BMASK_W] & ~br_resolve_ok;
          end
        end
        for (int l = 0; l < N_LANES; l++) begin
          if (fu_st_en[l]) begin
            r_q[fu_st_idx[l*PTR_W +: IDX_W]].addr     <= fu_addr[l*ADDR_W +: ADDR_W];
            r_q[fu_st_idx[l*PTR_W +: IDX_W]].data     <= fu_data[l*DATA_W +: DATA_W];
            r_q[fu_st_idx[l*PTR_W +: IDX_W]].addr_vld <= 1'b1;
          end
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
      logic              w_hit;
      logic              w_replay;
      logic [DATA_W-1:0] w_data;
      logic              w_ld_ok;
      logic              w_unused_st_wrap;

      // The entry index is taken from the low bits; the wrap bit is redundant.
      assign w_unused_st_wrap = fu_st_idx[l*PTR_W + IDX_W];

      sq_fwd_search #(
        .SQ_DEPTH (SQ_DEPTH)
      ) u_search (
        .i_q       (r_q),
        .i_head    (r_head),
        .i_ld_tail (fu_ld_tail[l*PTR_W +: PTR_W]),
        .i_ld_addr (fu_addr[l*ADDR_W +: ADDR_W]),
        .o_hit     (w_hit),
        .o_replay  (w_replay),
        .o_data    (w_data)
      );

      assign w_ld_ok                         = fu_ld_en[l] & ~reset;
      assign ld_fwd_hit[l]                   = w_ld_ok & w_hit;
      assign ld_replay[l]                    = w_ld_ok & w_replay;
      assign ld_fwd_data[l*DATA_W +: DATA_W] = w_ld_ok ? w_data : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/lsq_store_fu.md
Name: lsq_store_fu

Overview:
Parametrised successor memory functional unit for the R10K-style core. Serves N_LANES load/store issue lanes and owns a circular store queue of SQ_DEPTH entries. Performs store-to-load forwarding and detects loads that must replay. Drains retired stores to the dcache controller through a valid/ready handshake and recovers the tail on branch mispredict.

Parameters:
N_LANES, 2, issue lanes (dispatch allocate, execute, retire width)
SQ_DEPTH, 8, store queue entries; power of two, at least 2
ADDR_W, 64, byte address width
DATA_W, 64, store/load data width
TAG_W, 6, physical register tag width
BMASK_W, 4, branch mask width
PTR_W, $clog2(SQ_DEPTH)+1, queue pointer width; MSB is the wrap bit

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
disp_alloc  in  N_LANES  per-lane store allocate request; lane-ordered, lane 0 oldest
disp_bmask  in  N_LANES*BMASK_W  branch mask of each allocating store
sq_alloc_idx  out  N_LANES*PTR_W  pointer assigned to each allocating lane
sq_tail  out  PTR_W  current tail; snapshot by loads and by the branch stack
sq_n_free  out  $clog2(N_LANES+1)  free slots, saturated at N_LANES
fu_st_en  in  N_LANES  store executing (address and data valid)
fu_st_idx  in  N_LANES*PTR_W  queue entry written by the store
fu_ld_en  in  N_LANES  load executing
fu_ld_tail  in  N_LANES*PTR_W  sq_tail snapshot taken at the load's dispatch
fu_addr  in  N_LANES*ADDR_W  effective address, computed upstream
fu_data  in  N_LANES*DATA_W  store data
ld_fwd_hit  out  N_LANES  load satisfied by forwarding
ld_fwd_data  out  N_LANES*DATA_W  forwarded data
ld_replay  out  N_LANES  older store address unresolved; load must reissue
rob_n_retire  in  $clog2(N_LANES+1)  stores committed this cycle
br_mispredict  in  1  squash all unretired stores younger than the branch
br_recov_tail  in  PTR_W  tail snapshot to restore
br_resolve_ok  in  BMASK_W  one-hot; clear this bit from every entry's bmask
mem_req_valid  out  1  drain request to the dcache controller
mem_req_ready  in  1  dcache controller accepts the request
mem_req_addr  out  ADDR_W  drain address
mem_req_data  out  DATA_W  drain data
sq_empty  out  1  occupancy is zero

Behaviour:
- Reset: head, tail and retire pointers go to 0; all entries are cleared (addr_vld=0). sq_empty=1, sq_n_free=min(N_LANES,SQ_DEPTH), mem_req_valid=0. ld_fwd_hit, ld_replay and ld_fwd_data read 0. A reset asserted mid-drain drops the request with no completion.
- Occupancy is tail-head in PTR_W-bit arithmetic. Full when occupancy equals SQ_DEPTH. Equal pointers including the wrap bit mean empty.
- Allocate: the k-th set bit of disp_alloc takes tail+k. The entry is written with addr_vld=0 and its bmask, and tail advances by popcount next edge. The dispatcher never requests more than sq_n_free, and the block need not check this.
- Execute store: the entry at fu_st_idx latches addr, data and addr_vld=1 at the next edge.
- Load search (combinational, on registered state only): scan entries from head up to fu_ld_tail-1, youngest first.
  - The youngest entry with addr_vld and an equal address sets hit=1 with that entry's data.
  - If a younger store with addr_vld=0 lies between that match and the load, assert replay=1 and hit=0.
  - No match and no unresolved store: both outputs are 0 and the load goes to the dcache.
  - A store executing in the same cycle is not visible to the search and therefore appears unresolved.
- Retire: the retire pointer advances by rob_n_retire. Entries from head up to the retire pointer are committed.
- Drain: mem_req_valid=1 when head != retire pointer. addr and data come from the head entry and hold stable while valid && !ready. Head advances on valid && ready, at most one entry per cycle.
- Mispredict: tail <= br_recov_tail. The snapshot is never older than the retire pointer, so committed stores survive. Allocation and store execution in that cycle are ignored. Retire and drain in the same cycle still apply.
- br_resolve_ok clears that bit in every entry's bmask in the same edge.
- sq_n_free is computed from the registered state, so entries freed this cycle become visible next cycle.

Decomposition:
- Shared package mem_pkg holds: the sq_ptr_t typedef (PTR_W), the sq_entry_t struct {addr, data, addr_vld, bmask}, and the ptr_older(a,b,head) age-compare function.
- Sub-module sq_fwd_search: one combinational instance per lane. Inputs are the queue array, head and the lane's fu_ld_tail; outputs are hit, replay and data.

Test Plan:
- Reset: hold reset with clk running. Require sq_empty=1, sq_n_free=2, mem_req_valid=0. Release, allocate 2 stores: sq_alloc_idx={1,0}, sq_tail=2.
- Forward: store idx0 executes addr 0x100 data 0xAB. Next cycle a load with fu_ld_tail=1 at 0x100 gives hit=1, data=0xAB, replay=0. The same load at 0x108 gives hit=0, replay=0.
- Replay: stores 0 and 1 allocated, only store 0 executed at 0x100. A load with ld_tail=2 at 0x100 gives replay=1, hit=0.
- Full and wrap: 8 allocations give sq_n_free=0. Retire 2 and drain with ready=1 for 2 cycles, then allocate 2. Require indices 8 and 9 (wrap bit set) and sq_n_free=0.
- Drain stall: hold ready=0 for 3 cycles with valid=1. Require addr and data stable and head unchanged. ready=1 pops exactly one entry.
- Mispredict: tail=6, retired=2, recov_tail=4, with a drain pop in the same cycle. Require tail=4, head=1, occupancy 3, and entries 4-5 never drained.
